// File: rtl/intr_ctrl_pkg.sv
// Shared types and helpers for the prioritised interrupt controller.
// Channel index 0 is the highest priority everywhere in this block.
package intr_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    ACK  = 2'd2
  } state_t;

  localparam int MAX_IRQ = 16;
  localparam int IDX_W   = 4;

  // The spurious vector sits one slot past the last channel's vector.
  localparam int SPUR_OFFSET = 1;

  function automatic logic [IDX_W-1:0] lowest_set(input logic [MAX_IRQ-1:0] bits);
    lowest_set = '0;
    for (int i = MAX_IRQ - 1; i >= 0; i--) begin
      if (bits[i]) lowest_set = IDX_W'(i);
    end
  endfunction

endpackage

// File: rtl/intr_ctrl_prio_enc.sv
// Fixed-priority encoder: reports whether any bit is set and the index
// of the lowest set bit.
module prio_enc
  import intr_ctrl_pkg::*;
#(
  parameter int W = 8
) (
  input  logic [W-1:0]     req,
  output logic             found,
  output logic [IDX_W-1:0] idx
);

  assign found = |req;
  assign idx   = lowest_set(MAX_IRQ'(req));

endmodule

// File: rtl/intr_ctrl.sv
// Prioritised interrupt controller: latches edge/level requests, masks them,
// raises one request to the core and answers acknowledge with a vector.
module intr_ctrl
  import intr_ctrl_pkg::*;
#(
  parameter int               NUM_IRQ  = 8,
  parameter int               VEC_W    = 8,
  parameter logic [VEC_W-1:0] VEC_BASE = 8'h20
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [NUM_IRQ-1:0] irq,
  input  logic [NUM_IRQ-1:0] edge_mode,
  input  logic               mask_we,
  input  logic [NUM_IRQ-1:0] mask_wdata,
  input  logic               inta,
  input  logic               eoi,
  output logic               intr,
  output logic [VEC_W-1:0]   vector,
  output logic               vector_valid,
  output logic [NUM_IRQ-1:0] pending,
  output logic [NUM_IRQ-1:0] in_service
);

  state_t             state, next_state;
  logic [NUM_IRQ-1:0] irq_q;
  logic [NUM_IRQ-1:0] mask;
  logic [NUM_IRQ-1:0] eligible;
  logic               elig_found, isr_found, winner_valid;
  logic [IDX_W-1:0]   elig_idx, isr_idx;
  logic               ack_take, spur_take;
  logic [NUM_IRQ-1:0] win_onehot, isr_onehot;
  logic [NUM_IRQ-1:0] pending_next, in_service_next;
  logic [VEC_W-1:0]   win_vec, spur_vec;

  assign eligible = pending & ~mask;

  prio_enc #(.W(NUM_IRQ)) u_elig_enc (
    .req   (eligible),
    .found (elig_found),
    .idx   (elig_idx)
  );

  prio_enc #(.W(NUM_IRQ)) u_isr_enc (
    .req   (in_service),
    .found (isr_found),
    .idx   (isr_idx)
  );

  // Only a strictly higher-priority channel may preempt one in service.
  assign winner_valid = elig_found && (!isr_found || (elig_idx < isr_idx));
  assign win_onehot   = NUM_IRQ'(1) << elig_idx;
  assign isr_onehot   = NUM_IRQ'(1) << isr_idx;
  assign win_vec      = VEC_BASE + VEC_W'(elig_idx);
  assign spur_vec     = VEC_BASE + VEC_W'(NUM_IRQ - 1 + SPUR_OFFSET);
  assign intr         = (state == REQ);

  always_comb begin
    next_state = state;
    ack_take   = 1'b0;
    spur_take  = 1'b0;
    case (state)
      IDLE: begin
        if (inta) spur_take = 1'b1;
        else if (winner_valid) next_state = REQ;
      end
      REQ: begin
        if (inta) begin
          ack_take   = winner_valid;
          spur_take  = !winner_valid;
          next_state = winner_valid ? ACK : IDLE;
        end else if (!winner_valid) begin
          next_state = IDLE;
        end
      end
      ACK:     next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Edge channels: a new rising edge wins over the acknowledge clear.
  always_comb begin
    pending_next = pending;
    for (int i = 0; i < NUM_IRQ; i++) begin
      if (edge_mode[i]) begin
        if (irq[i] && !irq_q[i]) pending_next[i] = 1'b1;
        else if (ack_take && win_onehot[i]) pending_next[i] = 1'b0;
      end else begin
        pending_next[i] = irq[i];
      end
    end
  end

  // The eoi clear looks at the old in-service set, before a new bit lands.
  always_comb begin
    in_service_next = in_service;
    if (eoi && isr_found) in_service_next = in_service_next & ~isr_onehot;
    if (ack_take) in_service_next = in_service_next | win_onehot;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= IDLE;
      irq_q        <= '0;
      mask         <= '0;
      pending      <= '0;
      in_service   <= '0;
      vector       <= '0;
      vector_valid <= 1'b0;
    end else begin
      state        <= next_state;
      irq_q        <= irq;
      pending      <= pending_next;
      in_service   <= in_service_next;
      vector_valid <= ack_take || spur_take;
      if (mask_we) mask <= mask_wdata;
      if (ack_take) vector <= win_vec;
      else if (spur_take) vector <= spur_vec;
    end
  end

endmodule

// File: doc/intr_ctrl.md
# intr_ctrl

Parametrised prioritised interrupt controller sitting between peripheral interrupt sources and the processor core's single `interrupt` input. It latches up to NUM_IRQ requests (per-channel edge or level mode), applies a writable mask, and raises one request line to the core. It answers the core's acknowledge with a vector and tracks in-service channels for nested, fixed-priority handling. It generalises the single-line interrupt input of the current core to N prioritised channels with masking, vectoring and end-of-interrupt.

## Interface
- NUM_IRQ, 8, number of interrupt channels (1..16); channel 0 has the highest priority
- VEC_W, 8, vector width
- VEC_BASE, 8'h20, vector for channel 0; channel i returns VEC_BASE+i
- clk  in  1  single system clock, all logic on rising edge
- reset  in  1  synchronous, active-high; one clock; reset is synchronous and active-high
- irq  in  NUM_IRQ  request inputs, synchronous to clk
- edge_mode  in  NUM_IRQ  per channel: 1 = rising-edge triggered, 0 = level
- mask_we  in  1  write strobe for mask register
- mask_wdata  in  NUM_IRQ  new mask; 1 = channel masked
- inta  in  1  acknowledge from core, one-cycle pulse
- eoi  in  1  end-of-interrupt, one-cycle pulse
- intr  out  1  request to core
- vector  out  VEC_W  vector, qualified by vector_valid
- vector_valid  out  1  one-cycle vector strobe
- pending  out  NUM_IRQ  pending register
- in_service  out  NUM_IRQ  in-service register

## Operation
- Edge channel: pending[i] set when irq[i]=1 and irq_q[i]=0; cleared on acknowledge of i. Set wins over clear in the same cycle.
- Level channel: pending[i] = registered irq[i]; acknowledge does not clear it.
- Masked channels still latch pending but never request. A mask write takes effect the next cycle.
- Eligible = pending & ~mask. Winner = lowest-index eligible channel, and only if its index is strictly lower than the lowest-index set in_service bit. This gives nesting by higher priority only.
- FSM states: IDLE, REQ, ACK.
  - IDLE -> REQ when a winner exists; intr is high while in REQ.
  - REQ -> IDLE if the winner disappears before inta (deasserted or masked); intr drops.
  - REQ with inta -> ACK. The winner is re-evaluated in the inta cycle and captured. Its in_service bit is set. The pending bit is cleared if the channel is edge mode.
  - ACK -> IDLE unconditionally.
- inta in IDLE (spurious): vector = VEC_BASE+NUM_IRQ with vector_valid. in_service is unchanged. The FSM stays in IDLE.
- inta while in ACK is ignored.
- eoi clears the lowest-index set in_service bit. eoi with in_service = 0 has no effect.
- eoi and inta in the same cycle: both apply. The eoi clear is computed on in_service before the new bit is set.
- Reset: pending, in_service, mask, irq_q = 0; intr = 0; vector = 0; vector_valid = 0; state = IDLE. Reset mid-handshake abandons the handshake; no vector is issued.
- Vector arithmetic: VEC_BASE + index, truncated to VEC_W bits (wraps).

## Timing
- irq rising edge sampled at cycle t -> pending at t+1 -> intr at t+2.
- inta sampled at cycle t in REQ -> vector_valid = 1 with vector at t+1 for exactly one cycle. intr drops at t+1.
- Earliest next intr is at t+3 (ACK -> IDLE -> REQ).
- Mask write at t: that channel stops requesting from t+1; intr falls at t+2 if no other winner.
- eoi at t: in_service updated at t+1. A lower-priority pending channel can raise intr at t+2.
- All outputs are registered; there are no combinational input-to-output paths.

## Structure
- intr_ctrl_pkg holds:
  - the state enum (IDLE/REQ/ACK);
  - a `lowest_set` index function, shared by winner selection and eoi;
  - the spurious-vector offset constant.
- Sub-module prio_enc (parametrised by width) produces a found flag and an index. It is instantiated twice: once on the eligible vector, once on in_service.

## Test plan
- Single edge channel: defaults, irq[3] 0->1 at cycle 10 -> pending[3] at 11, intr at 12. inta at 14 -> vector = 8'h23 valid at 15. pending[3] = 0, in_service[3] = 1.
- Priority and nesting: irq[5] and irq[2] rise together -> acknowledge gives 8'h22. While in_service[2] is set, irq[1] rises -> intr is raised and the vector is 8'h21. irq[4] rises -> no intr until two eois.
- Masking: mask_wdata = 8'h08, irq[3] rises -> pending[3] = 1, intr stays 0. Unmask -> intr two cycles later.
- Level mode: edge_mode[6] = 0, irq[6] held high -> acknowledge gives 8'h26, and there is no re-request while in_service[6] is set. After eoi with irq[6] still high -> intr again.
- Withdrawal and spurious acknowledge: level irq[0] drops while in REQ -> intr falls and the FSM returns to IDLE. A following inta -> vector = 8'h28 with in_service = 0.
- Reset mid-handshake: reset asserted in the cycle inta arrives -> next cycle intr = 0, vector_valid = 0, pending = 0, in_service = 0.
